axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
AXI3-style responder backing a word-addressed on-chip SRAM array; the slave end of the bus that cpu_axi_interface/system cache drive as master. Used as the simulation/FPGA memory target behind mycpu_top's AXI master ports. Independent read and write channels, one outstanding burst each, INCR/FIXED/WRAP bursts.

Parameters:
MEM_AW, 12, log2 of memory depth in 32-bit words (4096 words = 16 KiB)
ID_WIDTH, 4, width of AXI ID fields
INIT_FILE, "", hex file loaded via $readmemh at elaboration; empty means no preload (array holds X)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
arid  in  ID_WIDTH  read ID
araddr  in  32  read byte address
arlen  in  4  beats-1
arsize  in  3  log2 bytes/beat (0..2)
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  echoes arid
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR
rlast  out  1  final beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  ID_WIDTH  write ID
awaddr  in  32  write byte address
awlen  in  4  beats-1
awsize  in  3  log2 bytes/beat
awburst  in  2  burst type
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  32  write data
wstrb  in  4  byte strobes
wlast  in  1  final beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  echoes awid
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (sync, rst=1 at posedge): arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rid/bid/rresp/bresp/rdata=0; both FSMs to IDLE; in-flight bursts discarded, memory contents kept.
- Word index = addr[MEM_AW+1:2]; upper bits ignored (aliasing wrap-around at memory end, no error).
- Read FSM: R_IDLE (arready=1) -> on arvalid&arready latch id/addr/len/size/burst, beat counter=0 -> R_FETCH (1 cycle, synchronous array read) -> R_DATA (rvalid=1, rlast=(cnt==len)). On rvalid&rready: if last -> R_IDLE, else advance address, -> R_FETCH. Latency: first rvalid 2 cycles after AR handshake; subsequent beats 2 cycles apart. rdata/rvalid stable while rready=0.
- Write FSM: W_IDLE (awready=1, wready=0) -> on AW handshake latch fields -> W_DATA (wready=1). Each W handshake writes bytes with wstrb[i]=1 same cycle, advances address. W beats before AW accepted are not taken (wready=0). Beat with cnt==len -> W_RESP (bvalid=1); wlast mismatch (early or missing at cnt==len) sets bresp=SLVERR, burst still terminated at cnt==len. W_RESP -> W_IDLE on bready.
- Address advance: FIXED none; INCR addr += (1<<size); WRAP increments within a (len+1)<<size aligned window, len must be 1,3,7,15.
- Errors: arsize/awsize >2, burst=11, or WRAP with illegal len -> burst still completes full beat count, rresp/bresp=SLVERR, writes suppressed, rdata=0.
- Simultaneous read and write to same word in same cycle: read returns old data; write completes.
- Narrow transfers: rdata returns the full 32-bit word; master selects lanes.

Optional Feature:
AXI_SLAVE_STALL_EN: when defined, a 16-bit LFSR (seed 16'hACE1, reset to seed) gates arready, awready, and wready (ready forced 0 when lfsr[0]=0) and adds a random 0/1 cycle bubble before each rvalid; functional results identical. When undefined, timing exactly as Behaviour, no LFSR logic.

Test Plan:
- Single write awaddr=0x100 wdata=0xDEADBEEF wstrb=4'hF, then read araddr=0x100 len=0 -> rdata=0xDEADBEEF, rresp=00, rlast=1, bid/rid echo 4'h3.
- INCR write len=3 at 0x200 data 1,2,3,4; INCR read len=3 -> beats 1,2,3,4, rlast only on 4th, first rvalid 2 cycles after AR.
- WRAP read len=3 size=2 at 0x20C after preloading 0x200..0x20C with A,B,C,D -> D,A,B,C.
- Byte write wstrb=4'b0010 wdata=0x0000AB00 over 0x11223344 -> read 0x1122AB44; rready held low 5 cycles -> rdata stable.
- arburst=11 len=1 -> two beats rresp=10 rdata=0; awsize=3 write -> bresp=10, memory unchanged.
- Assert rst mid-read-burst (after beat 1 of 4) -> next cycle rvalid=0, arready=1; new read completes normally.

Source files
------------

// File: rtl/axi_sram_if.sv
// AXI3-style bus bundle between a master (CPU/cache side) and the SRAM slave.
// Carries the five channels; clock and reset stay outside as plain ports.
interface axi_sram_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-style slave backed by a word-addressed on-chip SRAM.
// Independent read and write engines, one outstanding burst each,
// FIXED/INCR/WRAP bursts. Upper address bits alias onto the array.
// Optional build macro AXI_SLAVE_STALL_EN: an LFSR throttles the ready
// signals and inserts a random bubble before each read beat.
module axi_sram_slave #(
  parameter int    MEM_AW    = 12,
  parameter int    ID_WIDTH  = 4,
  parameter string INIT_FILE = ""
) (
  input logic       clk,
  input logic       rst,
  axi_sram_if.slave bus
);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
`ifdef AXI_SLAVE_STALL_EN
  localparam logic [1:0] R_HOLD  = 2'd3;
`endif

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  // Unsupported size, reserved burst type or a WRAP length that is not 2/4/8/16 beats.
  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
    logic wrap_bad;
    wrap_bad = (burst == BURST_WRAP) &&
               !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    return (size > 3'd2) || (burst == 2'b11) || wrap_bad;
  endfunction

  // WRAP keeps the low bits inside a (len+1)<<size window and carries the rest.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] step, mask, inc;
    step = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    inc  = addr + step;
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~mask) | (inc & mask);
      default:     return inc;
    endcase
  endfunction

  logic go;
`ifdef AXI_SLAVE_STALL_EN
  logic [15:0] lfsr;
  logic        bubble;

  // Free-running x^16+x^14+x^13+x^11+1 sequence used as a stall source.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign go     = lfsr[0];
  assign bubble = lfsr[1];
`else
  assign go = 1'b1;
`endif

  logic [1:0]          r_state;
  logic [ID_WIDTH-1:0] r_id;
  logic [31:0]         r_addr, r_data;
  logic [3:0]          r_len, r_cnt;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_err, r_valid, r_last, ar_hs;

  assign bus.arready = (r_state == R_IDLE) && go;
  assign ar_hs       = bus.arvalid && (r_state == R_IDLE) && go;
  assign r_valid     = (r_state == R_DATA);
  assign r_last      = r_valid && (r_cnt == r_len);
  assign bus.rvalid  = r_valid;
  assign bus.rlast   = r_last;
  assign bus.rid     = r_id;
  assign bus.rdata   = r_data;
  assign bus.rresp   = r_err ? RESP_SLVERR : RESP_OKAY;

  // Read engine: accept AR, fetch one word per beat, present it until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_id    <= bus.arid;
          r_addr  <= bus.araddr;
          r_len   <= bus.arlen;
          r_size  <= bus.arsize;
          r_burst <= bus.arburst;
          r_cnt   <= 4'd0;
          r_err   <= burst_err(bus.arsize, bus.arburst, bus.arlen);
          r_state <= R_FETCH;
        end
        R_FETCH: begin
          r_data  <= r_err ? 32'd0 : mem[r_addr[MEM_AW+1:2]];
`ifdef AXI_SLAVE_STALL_EN
          r_state <= bubble ? R_HOLD : R_DATA;
`else
          r_state <= R_DATA;
`endif
        end
        R_DATA: if (bus.rready) begin
          if (r_last) begin
            r_state <= R_IDLE;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_addr  <= next_addr(r_addr, r_size, r_len, r_burst);
            r_state <= R_FETCH;
          end
        end
        default: r_state <= R_DATA;
      endcase
    end
  end

  logic [1:0]          w_state;
  logic [ID_WIDTH-1:0] w_id;
  logic [31:0]         w_addr;
  logic [3:0]          w_len, w_cnt;
  logic [2:0]          w_size;
  logic [1:0]          w_burst;
  logic                w_err, w_lerr, aw_hs, w_hs, w_at_end, mem_we;

  assign bus.awready = (w_state == W_IDLE) && go;
  assign bus.wready  = (w_state == W_DATA) && go;
  assign aw_hs       = bus.awvalid && (w_state == W_IDLE) && go;
  assign w_hs        = bus.wvalid && (w_state == W_DATA) && go;
  assign w_at_end    = (w_cnt == w_len);
  assign mem_we      = w_hs && !w_err && !rst;
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bid     = w_id;
  assign bus.bresp   = (w_err || w_lerr) ? RESP_SLVERR : RESP_OKAY;

  // Write engine: accept AW, take beats until the counted last, then respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_err   <= 1'b0;
      w_lerr  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_id    <= bus.awid;
          w_addr  <= bus.awaddr;
          w_len   <= bus.awlen;
          w_size  <= bus.awsize;
          w_burst <= bus.awburst;
          w_cnt   <= 4'd0;
          w_err   <= burst_err(bus.awsize, bus.awburst, bus.awlen);
          w_lerr  <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          if (bus.wlast != w_at_end) w_lerr <= 1'b1;
          if (w_at_end) begin
            w_state <= W_RESP;
          end else begin
            w_cnt  <= w_cnt + 4'd1;
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
          end
        end
        W_RESP: if (bus.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane writes; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem[w_addr[MEM_AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a word-array reference model and
// a single negedge compare process for the R and B channels.
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_sram_if #(.ID_WIDTH(4)) bus ();
  axi_sram_slave #(.MEM_AW(12), .ID_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  logic [31:0] mdl [0:4095];
  rbeat_t      exp_r[$];
  bresp_t      exp_b[$];
  logic [31:0] got_r[$];
  int          beat_cyc[$];
  logic [31:0] wq[$];
  logic [1:0]  got_bresp;
  logic [3:0]  got_bid;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_data;
  rbeat_t      e;
  bresp_t      eb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mdl_err(input logic [2:0] size, input logic [1:0] burst,
                                 input logic [3:0] len);
    if (size > 3'd2) return 1'b1;
    if (burst == 2'b11) return 1'b1;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    return 1'b0;
  endfunction

  // Byte address of beat i, straight from the burst definitions.
  function automatic int unsigned beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [3:0] len,
                                            input logic [1:0] burst);
    int unsigned bytes, total, base;
    bytes = 1 << size;
    total = (len + 1) * bytes;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      base = a - (a % total);
      return base + (((a - base) + i * bytes) % total);
    end
    return a + i * bytes;
  endfunction

  function automatic int unsigned widx(input int unsigned a);
    return (a >> 2) % 4096;
  endfunction

  // Compare process: every accepted R/B beat against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("r_hold_valid", bus.rvalid, 1'b1);
        chk("r_hold_data", bus.rdata, prev_data);
      end
      hold_prev = bus.rvalid && !bus.rready;
      prev_data = bus.rdata;
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = exp_r.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rresp", bus.rresp, e.resp);
          chk("rlast", bus.rlast, e.last);
          chk("rid", bus.rid, e.id);
          got_r.push_back(bus.rdata);
          beat_cyc.push_back(cyc);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("bid", bus.bid, eb.id);
          chk("bresp", bus.bresp, eb.resp);
          got_bresp = bus.bresp;
          got_bid   = bus.bid;
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [3:0] strb, input bit bad_last);
    bit err, lerr;
    int n;
    int unsigned a;
    err  = mdl_err(size, burst, len);
    lerr = 1'b0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len;
    bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", 0, 1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = wq[i];
      bus.wstrb  = strb;
      bus.wlast  = bad_last ? (i == 0) : (i == int'(len));
      bus.wvalid = 1'b1;
      if (bus.wlast != (i == int'(len))) lerr = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", 0, 1);
      @(posedge clk); #1 bus.wvalid = 1'b0;
      if (!err) begin
        a = beat_addr(addr, i, size, len, burst);
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[widx(a)][8*b +: 8] = wq[i][8*b +: 8];
      end
    end
    exp_b.push_back('{id: id, resp: (err || lerr) ? 2'b10 : 2'b00});
    n = 0;
    while (exp_b.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin chk("b_timeout", 0, 1); exp_b.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic issue_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit rdy,
                            output int c0);
    bit err;
    int n;
    err = mdl_err(size, burst, len);
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{id: id,
                        data: err ? 32'd0 : mdl[widx(beat_addr(addr, i, size, len, burst))],
                        resp: err ? 2'b10 : 2'b00,
                        last: (i == int'(len))});
    got_r.delete();
    beat_cyc.delete();
    bus.rready = rdy;
    bus.arid = id; bus.araddr = addr; bus.arlen = len;
    bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 0, 1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    c0 = cyc;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int hold, input bit lat);
    int c0, n;
    issue_read(id, addr, len, size, burst, (hold == 0), c0);
    if (hold > 0) begin
      n = 0;
      while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
      repeat (hold) @(posedge clk);
      #1 bus.rready = 1'b1;
    end
    n = 0;
    while (exp_r.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin chk("r_timeout", 0, 1); exp_r.delete(); end
    if (lat) begin
      for (int k = 0; k <= int'(len); k++)
        if (k < beat_cyc.size()) chk("r_beat_cycle", beat_cyc[k] - c0, 1 + 2 * k);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, n;
    bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0; bus.rready = 1; bus.bready = 1;
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_arready", bus.arready, 1);
    chk("rst_awready", bus.awready, 1);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rid", bus.rid, 0);
    chk("rst_bid", bus.bid, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rdata", bus.rdata, 0);

    // Single word write/read with ID echo
    wq = '{32'hDEADBEEF};
    do_write(4'h3, 32'h100, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0);
    chk("single_bid", got_bid, 4'h3);
    chk("single_bresp", got_bresp, 2'b00);
    do_read(4'h3, 32'h100, 4'd0, 3'd2, 2'b01, 0, 1'b1);
    chk("single_rdata", got_r[0], 32'hDEADBEEF);

    // INCR burst of four with beat timing
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(4'h5, 32'h200, 4'd3, 3'd2, 2'b01, 4'hF, 1'b0);
    do_read(4'h5, 32'h200, 4'd3, 3'd2, 2'b01, 0, 1'b1);
    for (int i = 0; i < 4; i++) chk("incr_data", got_r[i], 32'(i + 1));

    // WRAP read starting mid-window
    wq = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_write(4'h1, 32'h200, 4'd3, 3'd2, 2'b01, 4'hF, 1'b0);
    do_read(4'h2, 32'h20C, 4'd3, 3'd2, 2'b10, 0, 1'b0);
    chk("wrap_b0", got_r[0], 32'hD);
    chk("wrap_b1", got_r[1], 32'hA);
    chk("wrap_b2", got_r[2], 32'hB);
    chk("wrap_b3", got_r[3], 32'hC);

    // Byte lane write, then read with rready held off
    wq = '{32'h11223344};
    do_write(4'h0, 32'h300, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0);
    wq = '{32'h0000AB00};
    do_write(4'h0, 32'h300, 4'd0, 3'd0, 2'b01, 4'b0010, 1'b0);
    do_read(4'h4, 32'h300, 4'd0, 3'd2, 2'b01, 5, 1'b0);
    chk("byte_rdata", got_r[0], 32'h1122AB44);

    // Reserved burst type and oversize write
    do_read(4'h6, 32'h300, 4'd1, 3'd2, 2'b11, 0, 1'b0);
    chk("err_r0", got_r[0], 32'd0);
    chk("err_r1", got_r[1], 32'd0);
    wq = '{32'hFFFFFFFF};
    do_write(4'h7, 32'h300, 4'd0, 3'd3, 2'b01, 4'hF, 1'b0);
    chk("err_bresp", got_bresp, 2'b10);
    do_read(4'h4, 32'h300, 4'd0, 3'd2, 2'b01, 0, 1'b0);
    chk("err_mem_kept", got_r[0], 32'h1122AB44);

    // WRAP with illegal length on the read side
    do_read(4'h8, 32'h200, 4'd2, 3'd2, 2'b10, 0, 1'b0);

    // wlast in the wrong place: data lands, response flags it
    wq = '{32'd5, 32'd6};
    do_write(4'h9, 32'h400, 4'd1, 3'd2, 2'b01, 4'hF, 1'b1);
    chk("wlast_bresp", got_bresp, 2'b10);
    do_read(4'h9, 32'h400, 4'd1, 3'd2, 2'b01, 0, 1'b0);

    // FIXED burst keeps hitting the same word
    wq = '{32'd7, 32'd8};
    do_write(4'hA, 32'h500, 4'd1, 3'd2, 2'b00, 4'hF, 1'b0);
    do_read(4'hA, 32'h500, 4'd1, 3'd2, 2'b00, 0, 1'b0);
    chk("fixed_b1", got_r[1], 32'd8);

    // Upper address bits alias onto the array
    wq = '{32'hCAFEF00D};
    do_write(4'hB, 32'h0000_4100, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0);
    do_read(4'hB, 32'h100, 4'd0, 3'd2, 2'b01, 0, 1'b0);
    chk("alias_rdata", got_r[0], 32'hCAFEF00D);

    // Reset in the middle of a read burst
    issue_read(4'hC, 32'h200, 4'd3, 3'd2, 2'b01, 1'b1, c0);
    n = 0;
    do begin @(posedge clk); n++; end while (got_r.size() < 1 && n < 50);
    if (n >= 50) chk("mid_rst_timeout", 0, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_r.delete();
    chk("mid_rst_rvalid", bus.rvalid, 0);
    chk("mid_rst_arready", bus.arready, 1);
    chk("mid_rst_rdata", bus.rdata, 0);
    do_read(4'hD, 32'h200, 4'd3, 3'd2, 2'b01, 0, 1'b1);
    chk("post_rst_b0", got_r[0], 32'hA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
